multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcodes
// and the ALU/mux select codes driven into the datapath.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that stall on the memory handshake and feed the timeout counter.
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a memory-wait watchdog that halts
// the controller in TRAP when a memory access never completes.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] instr_op_i,
  input  logic [OP_W-1:0] funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            ir_write_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      pc_src_o,
  output logic [3:0]      state_o,
  output logic            trap_o
);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       timeout;
  logic       unused_funct;

  assign unused_funct = ^funct_i;
  assign timeout      = (wait_cnt == 4'(MEM_TIMEOUT - 1)) && !mem_ready_i;
  assign state_o      = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_FETCH;
    else       state <= state_next;
  end

  // Counts consecutive stalled cycles; any progress or state change restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      wait_cnt <= 4'd0;
    else if (is_mem_wait(state) && !mem_ready_i && (state_next == state))
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= 4'd0;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_FETCH: begin
        if (mem_ready_i)  state_next = ST_DECODE;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_DECODE: begin
        if (instr_op_i == OP_W'(OP_LW) || instr_op_i == OP_W'(OP_SW))
          state_next = ST_MEM_ADDR;
        else if (instr_op_i == OP_W'(OP_R))    state_next = ST_R_EXEC;
        else if (instr_op_i == OP_W'(OP_BEQ))  state_next = ST_BRANCH;
        else if (instr_op_i == OP_W'(OP_J))    state_next = ST_JUMP;
        else if (instr_op_i == OP_W'(OP_ADDI)) state_next = ST_I_EXEC;
        else                                   state_next = ST_TRAP;
      end
      ST_MEM_ADDR:
        state_next = (instr_op_i == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready_i)  state_next = ST_MEM_WB;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_MEM_WR: begin
        if (mem_ready_i)  state_next = ST_FETCH;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_R_EXEC: state_next = ST_R_WB;
      ST_I_EXEC: state_next = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP:
        state_next = ST_FETCH;
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_TRAP;
    endcase
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    alu_op_o     = ALU_ADD;
    pc_src_o     = PC_ALU;
    trap_o       = 1'b0;
    unique case (state)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE:
        alu_src_b_o = SRCB_BOFF;
      ST_MEM_ADDR, ST_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_I_WB:
        reg_write_o = 1'b1;
      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_TARGET;
        pc_write_o  = zero_i;
      end
      ST_JUMP: begin
        pc_src_o   = PC_JUMP;
        pc_write_o = 1'b1;
      end
      ST_TRAP:
        trap_o = 1'b1;
      default: ;
    endcase
    // Reset must not let a half-finished access or write-back leak out.
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
  end

endmodule
